// File: rtl/mor1kx_wb_arbiter_marocchino.sv
// Write-back arbiter: picks one of LSU/ALU/MUL/DIV results per advance and registers it.
// Optional starvation promotion is enabled by defining MOR1KX_WB_ARB_STARVE_EN.
module mor1kx_wb_arbiter_marocchino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int STARVE_LIMIT         = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              padv_wb_i,
  input  logic                              pipeline_flush_i,
  input  logic [3:0]                        unit_req_i,
  input  logic [3:0]                        unit_rf_wb_i,
  input  logic [4*OPTION_RF_ADDR_WIDTH-1:0] unit_rfd_adr_i,
  input  logic [4*OPTION_OPERAND_WIDTH-1:0] unit_result_i,
  output logic [3:0]                        unit_grant_o,
  output logic                              wb_rf_wb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0]   wb_rfd_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   wb_result_o,
  output logic [1:0]                        wb_unit_o
);

  localparam int AW = OPTION_RF_ADDR_WIDTH;
  localparam int DW = OPTION_OPERAND_WIDTH;

  logic          arb_en_s;
  logic [3:0]    promoted_s;
  logic [3:0]    cand_s;
  logic [1:0]    grant_idx_s;
  logic          sel_rf_wb_s;
  logic [AW-1:0] sel_adr_s;
  logic [DW-1:0] sel_result_s;

  // Arbitration is live only on an unflushed advance with at least one requester
  always_comb begin
    arb_en_s = padv_wb_i & ~pipeline_flush_i & (unit_req_i != 4'b0000);
  end

`ifdef MOR1KX_WB_ARB_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] wait_cnt_r [4];

  // A unit whose wait counter reached the limit jumps ahead of fixed priority
  always_comb begin
    promoted_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      promoted_s[i] = unit_req_i[i] & (wait_cnt_r[i] == LIMIT);
    end
  end

  // Saturating per-unit count of lost advance cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        wait_cnt_r[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pipeline_flush_i || !unit_req_i[i] || unit_grant_o[i]) begin
          wait_cnt_r[i] <= 4'd0;
        end else if (padv_wb_i && (wait_cnt_r[i] != 4'd15)) begin
          wait_cnt_r[i] <= wait_cnt_r[i] + 4'd1;
        end
      end
    end
  end
`else
  logic [3:0] starve_limit_unused_s;

  // Pure fixed priority: nobody is ever promoted
  always_comb begin
    promoted_s            = 4'b0000;
    starve_limit_unused_s = 4'(STARVE_LIMIT);
  end
`endif

  // Lowest-index promoted unit wins, otherwise lowest-index requester
  always_comb begin
    cand_s      = (promoted_s != 4'b0000) ? promoted_s : unit_req_i;
    grant_idx_s = 2'd0;
    if (cand_s[0]) begin
      grant_idx_s = 2'd0;
    end else if (cand_s[1]) begin
      grant_idx_s = 2'd1;
    end else if (cand_s[2]) begin
      grant_idx_s = 2'd2;
    end else if (cand_s[3]) begin
      grant_idx_s = 2'd3;
    end else begin
      grant_idx_s = 2'd0;
    end
    if (arb_en_s) begin
      unit_grant_o = 4'b0001 << grant_idx_s;
    end else begin
      unit_grant_o = 4'b0000;
    end
  end

  // Select the winning unit's payload
  always_comb begin
    sel_rf_wb_s  = 1'b0;
    sel_adr_s    = '0;
    sel_result_s = '0;
    case (grant_idx_s)
      2'd0: begin
        sel_rf_wb_s  = unit_rf_wb_i[0];
        sel_adr_s    = unit_rfd_adr_i[0*AW +: AW];
        sel_result_s = unit_result_i[0*DW +: DW];
      end
      2'd1: begin
        sel_rf_wb_s  = unit_rf_wb_i[1];
        sel_adr_s    = unit_rfd_adr_i[1*AW +: AW];
        sel_result_s = unit_result_i[1*DW +: DW];
      end
      2'd2: begin
        sel_rf_wb_s  = unit_rf_wb_i[2];
        sel_adr_s    = unit_rfd_adr_i[2*AW +: AW];
        sel_result_s = unit_result_i[2*DW +: DW];
      end
      2'd3: begin
        sel_rf_wb_s  = unit_rf_wb_i[3];
        sel_adr_s    = unit_rfd_adr_i[3*AW +: AW];
        sel_result_s = unit_result_i[3*DW +: DW];
      end
      default: begin
        sel_rf_wb_s  = 1'b0;
        sel_adr_s    = '0;
        sel_result_s = '0;
      end
    endcase
  end

  // Write-back registers; flush only kills the RF write, the payload holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rf_wb_o   <= 1'b0;
      wb_rfd_adr_o <= '0;
      wb_result_o  <= '0;
      wb_unit_o    <= 2'd0;
    end else if (pipeline_flush_i) begin
      wb_rf_wb_o <= 1'b0;
    end else if (padv_wb_i) begin
      if (arb_en_s) begin
        wb_rf_wb_o   <= sel_rf_wb_s;
        wb_rfd_adr_o <= sel_adr_s;
        wb_result_o  <= sel_result_s;
        wb_unit_o    <= grant_idx_s;
      end else begin
        wb_rf_wb_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_wb_arbiter_marocchino.sv
// Randomized self-checking bench for the write-back arbiter against a behavioural model.
module tb_mor1kx_wb_arbiter_marocchino;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, padv, flush;
  logic [3:0]      req, rf_wb, grant;
  logic [4*AW-1:0] adr;
  logic [4*DW-1:0] res;
  logic            wb_rf_wb;
  logic [AW-1:0]   wb_adr;
  logic [DW-1:0]   wb_res;
  logic [1:0]      wb_unit;

  mor1kx_wb_arbiter_marocchino #(
    .OPTION_OPERAND_WIDTH(DW), .OPTION_RF_ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .padv_wb_i(padv), .pipeline_flush_i(flush),
    .unit_req_i(req), .unit_rf_wb_i(rf_wb), .unit_rfd_adr_i(adr), .unit_result_i(res),
    .unit_grant_o(grant), .wb_rf_wb_o(wb_rf_wb), .wb_rfd_adr_o(wb_adr),
    .wb_result_o(wb_res), .wb_unit_o(wb_unit)
  );

  int errors = 0;
  int checks = 0;

  // reference state
  logic          m_rf;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_res;
  logic [1:0]    m_unit;
  int            m_cnt [4];
  logic [3:0]    m_gnt;
  logic [3:0]    obs_gnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_grant();
    if (!padv || flush || req == 4'b0000) return 4'b0000;
`ifdef MOR1KX_WB_ARB_STARVE_EN
    for (int i = 0; i < 4; i++)
      if (req[i] && m_cnt[i] == LIM) return 4'b0001 << i;
`endif
    for (int i = 0; i < 4; i++)
      if (req[i]) return 4'b0001 << i;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_rf = 1'b0; m_adr = '0; m_res = '0; m_unit = 2'd0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge(input logic [3:0] g);
    if (flush) m_rf = 1'b0;
    else if (padv) begin
      if (g != 4'b0000) begin
        for (int i = 0; i < 4; i++)
          if (g[i]) begin
            m_rf = rf_wb[i]; m_adr = adr[i*AW +: AW]; m_res = res[i*DW +: DW]; m_unit = 2'(i);
          end
      end else m_rf = 1'b0;
    end
`ifdef MOR1KX_WB_ARB_STARVE_EN
    for (int i = 0; i < 4; i++) begin
      if (flush || !req[i] || g[i]) m_cnt[i] = 0;
      else if (padv && m_cnt[i] < 15) m_cnt[i]++;
    end
`endif
  endtask

  // one clock: inputs are already driven (we sit just after a falling edge)
  task automatic step();
    m_gnt = model_grant();
    #1;
    obs_gnt = grant;
    check("grant", grant, m_gnt);
    @(posedge clk);
    model_edge(m_gnt);
    #1;
    check("wb_rf_wb", wb_rf_wb, m_rf);
    check("wb_rfd_adr", wb_adr, m_adr);
    check("wb_result", wb_res, m_res);
    check("wb_unit", wb_unit, m_unit);
    @(negedge clk);
  endtask

  task automatic consume();
    req = req & ~m_gnt;
  endtask

  task automatic set_unit(input int i, input logic f, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1; rf_wb[i] = f; adr[i*AW +: AW] = a; res[i*DW +: DW] = d;
  endtask

  initial begin
    int got_at;
    rst_n = 1'b0; padv = 1'b0; flush = 1'b0; req = 4'b0000;
    rf_wb = 4'(4'($urandom)); adr = 20'($urandom); res = {$urandom, $urandom, $urandom, $urandom};
    model_reset();
    #3;
    check("reset_rf_wb", wb_rf_wb, 1'b0);
    check("reset_adr", wb_adr, 5'd0);
    check("reset_result", wb_res, 32'd0);
    check("reset_unit", wb_unit, 2'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU beats MUL under fixed priority
    padv = 1'b1;
    set_unit(1, 1'b1, 5'd3, 32'hA1B2C3D4);
    set_unit(2, 1'b1, 5'd9, 32'h0BADF00D);
    step();
    check("alu_grant", obs_gnt, 4'b0010);
    check("alu_unit", wb_unit, 2'd1);
    check("alu_result", wb_res, 32'hA1B2C3D4);
    consume();
    step(); consume();

    // store from LSU does not write the RF
    set_unit(0, 1'b0, 5'd4, 32'h12345678);
    step();
    check("store_grant", obs_gnt, 4'b0001);
    check("store_rf_wb", wb_rf_wb, 1'b0);
    consume();

    // LSU hammers every cycle while DIV waits
    got_at = 0;
    set_unit(3, 1'b1, 5'd21, 32'hD1D1D1D1);
    for (int c = 1; c <= 12; c++) begin
      if (!req[0]) set_unit(0, 1'b1, 5'($urandom), $urandom);
      step();
      if (obs_gnt[3] && got_at == 0) got_at = c;
      consume();
    end
`ifdef MOR1KX_WB_ARB_STARVE_EN
    check("starve_cycle", got_at, LIM + 1);
`else
    check("starve_cycle", got_at, 0);
`endif
    req[0] = 1'b0;
    if (req[3]) begin step(); consume(); end

    // flush wins over advance
    set_unit(3, 1'b1, 5'd30, 32'hFEEDFACE);
    flush = 1'b1;
    step();
    check("flush_grant", obs_gnt, 4'b0000);
    check("flush_rf_wb", wb_rf_wb, 1'b0);
    flush = 1'b0;
    step(); consume();

    // stall holds outputs, async reset clears them between edges
    set_unit(2, 1'b1, 5'd7, 32'h77777777);
    step(); consume();
    padv = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check("hold_adr", wb_adr, 5'd7);
    check("hold_rf_wb", wb_rf_wb, 1'b1);
    rst_n = 1'b0;
    #2;
    check("async_rf_wb", wb_rf_wb, 1'b0);
    check("async_adr", wb_adr, 5'd0);
    check("async_result", wb_res, 32'd0);
    check("async_unit", wb_unit, 2'd0);
    model_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      padv  = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < 4; i++)
        if (!req[i] && $urandom_range(0, 1) == 1)
          set_unit(i, 1'($urandom), 5'($urandom), $urandom);
      step();
      consume();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mor1kx_wb_arbiter_marocchino.md
MOR1KX_WB_ARBITER_MAROCCHINO -- requirements
Module: mor1kx_wb_arbiter_marocchino

Interface
REQ-001 Parameter OPTION_OPERAND_WIDTH, default 32, width of result data.
REQ-002 Parameter OPTION_RF_ADDR_WIDTH, default 5, width of destination register address.
REQ-003 Parameter STARVE_LIMIT, default 4, range 1..15; number of lost arbitration cycles before a requester is promoted.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous and active-low.
REQ-006 padv_wb_i  input  1  write-back advance; arbitration happens only when high.
REQ-007 pipeline_flush_i  input  1  flush; cancels arbitration and clears write-back state.
REQ-008 unit_req_i  input  4  per-unit result-ready request; unit 0 = LSU, 1 = ALU, 2 = MUL, 3 = DIV.
REQ-009 unit_rf_wb_i  input  4  per-unit "writes RF" flag, valid while the matching request is high.
REQ-010 unit_rfd_adr_i  input  4*OPTION_RF_ADDR_WIDTH  packed destination addresses, unit n at slice n.
REQ-011 unit_result_i  input  4*OPTION_OPERAND_WIDTH  packed results, unit n at slice n.
REQ-012 unit_grant_o  output  4  one-hot-or-zero combinational grant.
REQ-013 wb_rf_wb_o  output  1  registered RF write enable.
REQ-014 wb_rfd_adr_o  output  OPTION_RF_ADDR_WIDTH  registered destination address.
REQ-015 wb_result_o  output  OPTION_OPERAND_WIDTH  registered write-back data.
REQ-016 wb_unit_o  output  2  registered index of the unit that won the last grant.

Function
REQ-017 unit_grant_o SHALL be zero whenever padv_wb_i is low, pipeline_flush_i is high, or unit_req_i is zero.
REQ-018 Otherwise exactly one requesting unit SHALL be granted: the lowest-index promoted unit if any unit is promoted, else the lowest-index requester.
REQ-019 A unit SHALL hold req, rf_wb, rfd_adr and result stable from request assertion until the cycle its grant is high; the request is consumed in that cycle.
REQ-020 On a granted edge: wb_rf_wb_o <= granted unit's rf_wb; wb_rfd_adr_o, wb_result_o, wb_unit_o <= granted unit's values (latency one cycle).
REQ-021 On padv_wb_i high with no request and no flush: wb_rf_wb_o <= 0; wb_rfd_adr_o, wb_result_o, wb_unit_o hold.
REQ-022 With padv_wb_i low and no flush, all registered outputs SHALL hold.
REQ-023 pipeline_flush_i SHALL clear wb_rf_wb_o on the next edge and take precedence over padv_wb_i in the same cycle.

Reset
REQ-024 rst_n low SHALL immediately force wb_rf_wb_o=0, wb_rfd_adr_o=0, wb_result_o=0, wb_unit_o=0 and all wait counters to 0, regardless of clk.
REQ-025 Reset deasserted mid-request SHALL cause no grant to be lost or duplicated: arbitration restarts from fixed priority on the first padv_wb_i cycle.

Configuration
REQ-026 Macro MOR1KX_WB_ARB_STARVE_EN defined: each unit has a 4-bit saturating wait counter incremented on every padv_wb_i cycle in which it requests and is not granted, cleared when granted, when its request is low, or on flush; a unit is promoted when its counter equals STARVE_LIMIT.
REQ-027 Macro MOR1KX_WB_ARB_STARVE_EN undefined: no counters exist, no unit is ever promoted, arbitration is pure fixed priority (0 highest).

Verification
REQ-028 Reset, then unit_req_i=4'b0110, padv=1 -> unit_grant_o=4'b0010; next cycle wb_unit_o=1, wb_result_o=ALU data.
REQ-029 unit_req_i=4'b0001, rf_wb=0 (store), padv=1 -> grant 4'b0001, next cycle wb_rf_wb_o=0.
REQ-030 unit 0 requesting every cycle, unit 3 held high, STARVE_LIMIT=4, macro defined -> unit 3 granted on 5th padv cycle; macro undefined -> unit 3 never granted.
REQ-031 Request 4'b1000 with padv=1 and pipeline_flush_i=1 -> unit_grant_o=0, next cycle wb_rf_wb_o=0, wait counters 0.
REQ-032 Grant unit 2 with rfd_adr=5'd7, then padv=0 for 3 cycles -> wb_rfd_adr_o stays 7, wb_rf_wb_o stays 1; rst_n pulsed low between edges -> outputs 0 immediately.
